mem_arbiter: RTL

// Two-requester arbiter sharing the single synchronous memory port between the risc_v core (M0) and a

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/arb_pick.sv | 40 ++++
 rtl/mem_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master memory arbiter: owner encoding, request bundle
// and the default access code driven when the port is idle.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_M0,
    OWN_M1
  } arb_owner_t;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  typedef struct packed {
    logic        req;
    logic        lock;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  funct3;
  } arb_req_t;

endpackage

// File: rtl/arb_pick.sv
// Grant selection for two requesters: a bounded burst lock, then fixed priority
// or round-robin against the last accepted master. Purely combinational.
module arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int MAX_LOCK   = 4,
  parameter int CNT_W      = 3
) (
  input  logic [1:0]       req,
  input  arb_owner_t       last_owner,
  input  logic [CNT_W-1:0] lock_cnt,
  output logic [1:0]       gnt
);

  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

  logic last_m1;
  logic pick_m1;

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
    gnt     = 2'b00;
    last_m1 = (last_owner == OWN_M1);
    pick_m1 = !last_m1;
    // A non-zero count means the last acceptance was locked; once it reaches the bound the waiter wins.
    if (lock_cnt != '0) begin
      pick_m1 = (lock_cnt < LOCK_MAX) ? last_m1 : !last_m1;
    end else if (FIXED_PRIO) begin
      pick_m1 = 1'b0;
    end
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = pick_m1 ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory port between the core (M0) and a loader/DMA master (M1),
// forwarding one request per cycle and steering the 1-cycle read data back to its owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int MAX_LOCK   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic        m0_wen,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  input  logic [2:0]  m0_funct3,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rd,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic        m1_wen,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  input  logic [2:0]  m1_funct3,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rd,
  output logic        mem_wen,
  output logic [31:0] mem_ra,
  output logic [31:0] mem_wa,
  output logic [31:0] mem_wd,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rd
);

  localparam int               CNT_W    = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_req_t         m0, m1, sel;
  logic [1:0]       pick, gnt;
  logic             accept;
  arb_owner_t       acc_owner;
  arb_owner_t       last_owner, rd_owner;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;

  assign m0 = '{req: m0_req, lock: m0_lock, wen: m0_wen, addr: m0_addr, wd: m0_wd, funct3: m0_funct3};
  assign m1 = '{req: m1_req, lock: m1_lock, wen: m1_wen, addr: m1_addr, wd: m1_wd, funct3: m1_funct3};

  arb_pick #(
    .FIXED_PRIO (FIXED_PRIO),
    .MAX_LOCK   (MAX_LOCK),
    .CNT_W      (CNT_W)
  ) u_pick (
    .req        ({m1.req, m0.req}),
    .last_owner (last_owner),
    .lock_cnt   (lock_cnt),
    .gnt        (pick)
  );

  // Grants are forced low while reset is asserted so nothing reaches memory mid-reset.
  assign gnt       = rst_n ? pick : 2'b00;
  assign accept    = |gnt;
  assign acc_owner = gnt[1] ? OWN_M1 : OWN_M0;
  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];

  always_comb begin
    sel = '0;
    if (gnt[0]) begin
      sel = m0;
    end else if (gnt[1]) begin
      sel = m1;
    end
    mem_wen    = sel.wen;
    mem_ra     = sel.addr;
    mem_wa     = sel.addr;
    mem_wd     = sel.wd;
    mem_funct3 = accept ? sel.funct3 : FUNCT3_WORD;
  end

  // Burst length of consecutive locked acceptances by one master, saturating at the bound.
  always_comb begin
    lock_cnt_nxt = '0;
    if (accept && sel.lock) begin
      if (acc_owner == last_owner && lock_cnt != '0) begin
        lock_cnt_nxt = (lock_cnt >= LOCK_MAX) ? LOCK_MAX : lock_cnt + CNT_ONE;
      end else begin
        lock_cnt_nxt = CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= OWN_M1;
      lock_cnt   <= '0;
      rd_owner   <= OWN_NONE;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (accept) begin
        last_owner <= acc_owner;
      end
      lock_cnt <= lock_cnt_nxt;
      rd_owner <= (accept && !sel.wen) ? acc_owner : OWN_NONE;
    end
  end

  // Return path is steered by the registered owner, so a grant switch never drops read data.
  assign m0_rvalid = (rd_owner == OWN_M0);
  assign m1_rvalid = (rd_owner == OWN_M1);
  assign m0_rd     = m0_rvalid ? mem_rd : 32'h0;
  assign m1_rd     = m1_rvalid ? mem_rd : 32'h0;

endmodule
